// File: rtl/ppu_oam_dma_pkg.sv
// Shared definitions for the OAM DMA block: bus addresses and DMA state encodings.
package ppu_oam_dma_pkg;

  localparam logic [15:0] PPU_REG_OAMDATA = 16'h2004;
  localparam logic [15:0] APU_REG_OAMDMA  = 16'h4014;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/ppu_oam_dma.sv
// OAM DMA for $4014: halts the CPU and copies page $PP00-$PPFF to OAMDATA via read/write pairs.
// Latency: first DMA cycle follows the trigger edge; 513 or 514 halted cycles depending on parity.
module ppu_oam_dma
  import ppu_oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = APU_REG_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = PPU_REG_OAMDATA
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rstn,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic        o_cpu_rdy,
  output logic        o_dma_active,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_wn,
  output logic [7:0]  o_dma_wdata,
  input  logic [7:0]  i_dma_rdata
);

  dma_state_t state, state_nxt;
  logic [7:0] page;
  logic [7:0] cnt;
  logic [7:0] data;
  logic       r_odd;
  logic       trigger;

  assign trigger = (state == IDLE) && (i_bus_addr == DMA_REG_ADDR) && !i_bus_wn;

  always_ff @(posedge i_cpu_clk) begin
    if (!i_cpu_rstn) begin
      state <= IDLE;
      page  <= 8'h00;
      cnt   <= 8'h00;
      data  <= 8'h00;
      r_odd <= 1'b0;
    end else begin
      state <= state_nxt;
      r_odd <= ~r_odd;
      if (trigger) begin
        page <= i_bus_wdata;
        cnt  <= 8'h00;
      end
      if (state == READ)  data <= i_dma_rdata;
      // cnt wraps to 0 only on the final WRITE, so reads never leave the page
      if (state == WRITE) cnt  <= cnt + 8'h01;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = HALT;
      HALT:    state_nxt = r_odd ? ALIGN : READ;
      ALIGN:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = (cnt == 8'hFF) ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_cpu_rdy    = 1'b1;
    o_dma_active = 1'b0;
    o_dma_addr   = 16'h0000;
    o_dma_wn     = 1'b1;
    o_dma_wdata  = 8'h00;
    case (state)
      HALT, ALIGN: begin
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
        o_dma_addr   = {page, 8'h00};
      end
      READ: begin
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
        o_dma_addr   = {page, cnt};
      end
      WRITE: begin
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
        o_dma_addr   = OAM_DATA_ADDR;
        o_dma_wn     = 1'b0;
        o_dma_wdata  = data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Directed bench for ppu_oam_dma with a combinational source bus and an OAMADDR/OAM model.
module tb_ppu_oam_dma;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] bus_addr = 16'h0000;
  logic        bus_wn = 1'b1;
  logic [7:0]  bus_wdata = 8'h00;
  logic        cpu_rdy, dma_active, dma_wn;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit bus_mode = 1'b0;

  logic [7:0]  ram [0:65535];
  logic [7:0]  oam [0:255];
  logic [7:0]  oam_addr = 8'h55;

  logic [15:0] rec_addr [0:599];
  logic        rec_wn   [0:599];
  logic [7:0]  rec_wd   [0:599];
  logic        rec_act  [0:599];
  logic        rec_rdy  [0:599];

  always #5 clk = ~clk;

  ppu_oam_dma dut (
    .i_cpu_clk   (clk),
    .i_cpu_rstn  (rstn),
    .i_bus_addr  (bus_addr),
    .i_bus_wn    (bus_wn),
    .i_bus_wdata (bus_wdata),
    .o_cpu_rdy   (cpu_rdy),
    .o_dma_active(dma_active),
    .o_dma_addr  (dma_addr),
    .o_dma_wn    (dma_wn),
    .o_dma_wdata (dma_wdata),
    .i_dma_rdata (dma_rdata)
  );

  assign dma_rdata = bus_mode ? ram[dma_addr] : (dma_addr[7:0] ^ 8'h5A);

  // Expected r_odd parity: cyc mirrors the count of edges since the last reset edge.
  always @(posedge clk) cyc <= !rstn ? 0 : cyc + 1;

  // ppu_cfg stand-in: CPU writes set OAMADDR, DMA writes to OAMDATA fill OAM and bump it
  always @(posedge clk) begin
    if (!dma_active && bus_addr == 16'h2003 && !bus_wn)
      oam_addr <= bus_wdata;
    else if (dma_active && dma_addr == 16'h2004 && !dma_wn) begin
      oam[oam_addr] <= dma_wdata;
      oam_addr      <= oam_addr + 8'h01;
    end
  end

  task automatic check_idle(input string name);
    tests++;
    if (cpu_rdy !== 1'b1 || dma_active !== 1'b0 || dma_wn !== 1'b1 ||
        dma_addr !== 16'h0000 || dma_wdata !== 8'h00) begin
      fails++;
      $display("FAIL %s: rdy=%b active=%b wn=%b addr=%h wdata=%h, required 1 0 1 0000 00",
               name, cpu_rdy, dma_active, dma_wn, dma_addr, dma_wdata);
    end
  endtask

  // Trigger a DMA of page pg with the HALT-cycle parity odd, record every halted cycle,
  // and check the sequence. do_rst pulls reset at the WRITE of byte 100.
  task automatic run_dma(input logic [7:0] pg, input bit odd, input bit retrig,
                         input bit do_rst, input string name);
    int n;
    int pre;
    int guard;
    int e_pre, e_rd, e_wr, e_dat, e_act;
    logic [7:0] exp_d;
    logic [7:0] idx;
    pre = odd ? 2 : 1;
    @(negedge clk);
    guard = 0;
    while ((((cyc + 1) & 1) != int'(odd)) && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = pg;
    @(negedge clk);
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    n = 0;
    while (n < 600 && cpu_rdy !== 1'b1) begin
      rec_addr[n] = dma_addr; rec_wn[n] = dma_wn; rec_wd[n] = dma_wdata;
      rec_act[n] = dma_active; rec_rdy[n] = cpu_rdy;
      if (retrig && n == 40) begin
        bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = 8'h07;
      end else if (retrig && n == 41) begin
        bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
      end
      if (do_rst && n == pre + 201) rstn = 1'b0;
      n++;
      @(negedge clk);
    end
    rstn = 1'b1;
    if (do_rst) begin
      tests++;
      if (n !== pre + 202) begin
        fails++;
        $display("FAIL %s_reset_abort: halted cycles %0d, required %0d", name, n, pre + 202);
      end
      tests++;
      if (rec_addr[pre + 201] !== 16'h2004 || rec_wd[pre + 201] !== (8'd100 ^ 8'h5A)) begin
        fails++;
        $display("FAIL %s_byte100: addr=%h data=%h, required 2004 %h",
                 name, rec_addr[pre + 201], rec_wd[pre + 201], 8'd100 ^ 8'h5A);
      end
      check_idle({name, "_after_reset"});
      return;
    end
    tests++;
    if (n !== 512 + pre) begin
      fails++;
      $display("FAIL %s_halt_cycles: got %0d, required %0d", name, n, 512 + pre);
    end
    check_idle({name, "_resume"});
    if (n == 512 + pre) begin
      e_pre = 0; e_rd = 0; e_wr = 0; e_dat = 0; e_act = 0;
      for (int i = 0; i < n; i++)
        if (rec_act[i] !== 1'b1 || rec_rdy[i] !== 1'b0) e_act++;
      for (int i = 0; i < pre; i++)
        if (rec_addr[i] !== {pg, 8'h00} || rec_wn[i] !== 1'b1) e_pre++;
      for (int i = 0; i < 256; i++) begin
        idx = i[7:0];
        exp_d = bus_mode ? ram[{pg, idx}] : (idx ^ 8'h5A);
        if (rec_addr[pre + 2*i] !== {pg, idx} || rec_wn[pre + 2*i] !== 1'b1) e_rd++;
        if (rec_addr[pre + 2*i + 1] !== 16'h2004 || rec_wn[pre + 2*i + 1] !== 1'b0) e_wr++;
        if (rec_wd[pre + 2*i + 1] !== exp_d) e_dat++;
      end
      tests++;
      if (e_act != 0) begin
        fails++; $display("FAIL %s_rdy_active: %0d bad cycles, required 0", name, e_act);
      end
      tests++;
      if (e_pre != 0) begin
        fails++; $display("FAIL %s_halt_align: %0d bad cycles, required 0", name, e_pre);
      end
      tests++;
      if (e_rd != 0 || rec_addr[pre] !== {pg, 8'h00} || rec_addr[pre + 510] !== {pg, 8'hFF}) begin
        fails++;
        $display("FAIL %s_reads: %0d bad, first=%h last=%h, required 0 %h %h",
                 name, e_rd, rec_addr[pre], rec_addr[pre + 510], {pg, 8'h00}, {pg, 8'hFF});
      end
      tests++;
      if (e_wr != 0) begin
        fails++; $display("FAIL %s_write_addr: %0d bad, required 0", name, e_wr);
      end
      tests++;
      if (e_dat != 0) begin
        fails++; $display("FAIL %s_write_data: %0d bad, required 0", name, e_dat);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check_idle("idle_10");
  endtask

  task automatic test_ignored_accesses();
    int bad;
    bad = 0;
    bus_addr = 16'h4014; bus_wn = 1'b1; bus_wdata = 8'h02;
    @(negedge clk);
    bus_addr = 16'h4015; bus_wn = 1'b0;
    @(negedge clk);
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    repeat (4) begin
      if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL no_trigger: %0d halted cycles, required 0", bad);
    end
  endtask

  task automatic test_even_dma();  run_dma(8'h02, 1'b0, 1'b0, 1'b0, "even");  endtask
  task automatic test_odd_dma();   run_dma(8'h02, 1'b1, 1'b0, 1'b0, "odd");   endtask
  task automatic test_retrigger(); run_dma(8'h02, 1'b0, 1'b1, 1'b0, "retrig"); endtask

  task automatic test_mid_reset();
    run_dma(8'h02, 1'b1, 1'b0, 1'b1, "midrst");
    run_dma(8'h03, 1'b0, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    run_dma(8'h20, 1'b1, 1'b0, 1'b0, "page20");
  endtask

  task automatic test_oam_integration();
    int bad;
    for (int a = 0; a < 256; a++) ram[16'h0700 + a] = 8'((a * 37 + 11) ^ (a >> 3));
    bus_mode = 1'b1;
    @(negedge clk);
    bus_addr = 16'h2003; bus_wn = 1'b0; bus_wdata = 8'h00;
    @(negedge clk);
    bus_addr = 16'h0000; bus_wn = 1'b1;
    run_dma(8'h07, 1'b0, 1'b0, 1'b0, "oam");
    bad = 0;
    for (int a = 0; a < 256; a++) if (oam[a] !== ram[16'h0700 + a]) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL oam_contents: %0d bytes differ, required 0", bad);
    end
    tests++;
    if (oam_addr !== 8'h00) begin
      fails++; $display("FAIL oamaddr_wrap: got %h, required 00", oam_addr);
    end
    bus_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ignored_accesses();
    test_even_dma();
    test_odd_dma();
    test_retrigger();
    test_mid_reset();
    test_back_to_back();
    test_oam_integration();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
